// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared fetch-unit constants and FSM state encoding
package ifu_fetch_pkg;

  localparam int              CORE_XLEN     = 32;
  localparam logic [31:0]     CORE_RESET_PC = 32'h0000_0000;
  localparam logic [31:0]     CORE_NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - synchronous FIFO with flush and occupancy count for the fetch buffer
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & valid & ~flush;

  // Push at full is safe with a same-cycle pop: the head is read before the slot is rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
    end
  end

  assign rdata = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - PC owner, imem request/response tracking and fetch buffer; IFU_PERF_CNT_EN adds drop/starve counters
module ifu_fetch import ifu_fetch_pkg::*; #(
  parameter int              XLEN       = CORE_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = CORE_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_drop_o,
  output logic [31:0]     perf_starve_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   resp_pc_q;
  logic [XLEN-1:0]   target_pc;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     disc_q, disc_d;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     inflight;
  logic [2*XLEN-1:0] head;
  logic              grant;
  logic              drop;
  logic              push;
  logic              pop;
  logic              unused_pc_lsbs;

  assign target_pc      = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_pc_lsbs = ^redirect_pc_i[1:0];

  // Requests are capped so every response already owns a FIFO slot when it arrives.
  assign inflight    = out_q + fifo_count;
  assign imem_req_o  = (state_q == S_FETCH) & ~redirect_valid_i & (inflight < CW'(FIFO_DEPTH));
  assign imem_addr_o = pc_q;
  assign grant       = imem_req_o & imem_gnt_i;
  assign drop        = imem_rvalid_i & (redirect_valid_i | (disc_q != '0));
  assign push        = imem_rvalid_i & ~drop;
  assign pop         = inst_valid_o & inst_ready_i;

  assign out_d = out_q + CW'(grant) - CW'(imem_rvalid_i);

  always_comb begin
    disc_d = disc_q;
    if (redirect_valid_i)                     disc_d = out_q - CW'(imem_rvalid_i);
    else if (imem_rvalid_i && disc_q != '0)   disc_d = disc_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:           state_d = S_FETCH;
      S_FETCH, S_FLUSH: state_d = (disc_d != '0) ? S_FLUSH : S_FETCH;
      default:          state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      disc_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      if (redirect_valid_i) begin
        pc_q      <= target_pc;
        resp_pc_q <= target_pc;
      end else begin
        if (grant) pc_q      <= pc_q + XLEN'(4);
        if (push)  resp_pc_q <= resp_pc_q + XLEN'(4);
      end
    end
  end

  ifu_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid_i),
    .push  (push),
    .wdata ({resp_pc_q, imem_rdata_i}),
    .pop   (pop),
    .rdata (head),
    .valid (inst_valid_o),
    .count (fifo_count)
  );

  assign inst_pc_o = inst_valid_o ? head[2*XLEN-1:XLEN] : '0;
  assign inst_o    = inst_valid_o ? head[XLEN-1:0]      : '0;

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_drop_o   <= '0;
      perf_starve_o <= '0;
    end else begin
      if (drop && perf_drop_o != '1) perf_drop_o <= perf_drop_o + 1'b1;
      if (!inst_valid_o && state_q == S_FETCH && perf_starve_o != '1)
        perf_starve_o <= perf_starve_o + 1'b1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
